// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mandel_pkg
//  Description : Shared fixed-point width, coordinate type and reset view.
//  Revision    : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int W    = 14;
    localparam int FRAC = 12;

    typedef logic signed [W-1:0] coord_t;

    localparam coord_t X_START_RST = 14'h2000;
    localparam coord_t X_STEP_RST  = 14'h0013;
    localparam coord_t Y_START_RST = 14'h2C00;
    localparam coord_t Y_STEP_RST  = 14'h0015;

endpackage
`default_nettype wire

// File: rtl/mandel_coord_sequencer_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a bus of host pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/mandel_coord_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mandel_coord_sequencer
//  Description : Double-buffered view parameters and raster-locked c stepping.
//  Revision    : 1.0 - initial release
// ============================================================================
module mandel_coord_sequencer #(
    parameter int           W           = mandel_pkg::W,
    parameter logic [W-1:0] X_START_RST = mandel_pkg::X_START_RST,
    parameter logic [W-1:0] X_STEP_RST  = mandel_pkg::X_STEP_RST,
    parameter logic [W-1:0] Y_START_RST = mandel_pkg::Y_START_RST,
    parameter logic [W-1:0] Y_STEP_RST  = mandel_pkg::Y_STEP_RST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] value_in,
    input  logic         input_x,
    input  logic         input_en,
    input  logic         frame_start,
    input  logic         line_start,
    input  logic         pixel_adv,
    output logic [W-1:0] c_re,
    output logic [W-1:0] c_im,
    output logic         cfg_pending,
    output logic         cfg_updated
);

    import mandel_pkg::*;

    logic [W+1:0] w_sync_d;
    logic [W+1:0] w_sync_q;
    logic         w_en;
    logic         w_sel_x;
    logic [W-1:0] w_val;
    logic         w_wr;
    logic         w_commit;

    logic         r_en_q;
    logic         r_ptr_x;
    logic         r_ptr_y;
    logic         r_dirty;
    logic         r_cfg_updated;
    logic [W-1:0] r_sh_x_start, r_sh_x_step, r_sh_y_start, r_sh_y_step;
    logic [W-1:0] r_x_start, r_x_step, r_y_start, r_y_step;
    logic [W-1:0] r_c_re, r_c_im;

    assign w_sync_d = {input_en, input_x, value_in};

    sync2 #(
        .WIDTH (W + 2)
    ) u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (w_sync_d),
        .q     (w_sync_q)
    );

    assign w_en     = w_sync_q[W+1];
    assign w_sel_x  = w_sync_q[W];
    assign w_val    = w_sync_q[W-1:0];
    assign w_wr     = w_en & ~r_en_q;
    // Only commit complete start/step pairs so the view never mixes old and new.
    assign w_commit = frame_start & r_dirty & ~r_ptr_x & ~r_ptr_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q       <= 1'b0;
            r_ptr_x      <= 1'b0;
            r_ptr_y      <= 1'b0;
            r_sh_x_start <= X_START_RST;
            r_sh_x_step  <= X_STEP_RST;
            r_sh_y_start <= Y_START_RST;
            r_sh_y_step  <= Y_STEP_RST;
        end else begin
            r_en_q <= w_en;
            if (w_wr) begin
                if (w_sel_x) begin
                    if (r_ptr_x) r_sh_x_step  <= w_val;
                    else         r_sh_x_start <= w_val;
                    r_ptr_x <= ~r_ptr_x;
                end else begin
                    if (r_ptr_y) r_sh_y_step  <= w_val;
                    else         r_sh_y_start <= w_val;
                    r_ptr_y <= ~r_ptr_y;
                end
            end
        end
    end

    // A write coinciding with a commit wins, leaving dirty set for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty       <= 1'b0;
            r_cfg_updated <= 1'b0;
            r_x_start     <= X_START_RST;
            r_x_step      <= X_STEP_RST;
            r_y_start     <= Y_START_RST;
            r_y_step      <= Y_STEP_RST;
        end else begin
            r_cfg_updated <= w_commit;
            if (w_wr)          r_dirty <= 1'b1;
            else if (w_commit) r_dirty <= 1'b0;
            if (w_commit) begin
                r_x_start <= r_sh_x_start;
                r_x_step  <= r_sh_x_step;
                r_y_start <= r_sh_y_start;
                r_y_step  <= r_sh_y_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_re <= X_START_RST;
            r_c_im <= Y_START_RST;
        end else if (frame_start) begin
            r_c_re <= w_commit ? r_sh_x_start : r_x_start;
            r_c_im <= w_commit ? r_sh_y_start : r_y_start;
        end else if (line_start) begin
            r_c_re <= r_x_start;
            r_c_im <= r_c_im + r_y_step;
        end else if (pixel_adv) begin
            r_c_re <= r_c_re + r_x_step;
        end
    end

    assign c_re        = r_c_re;
    assign c_im        = r_c_im;
    assign cfg_pending = r_dirty;
    assign cfg_updated = r_cfg_updated;

endmodule
`default_nettype wire

// File: tb/tb_mandel_coord_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mandel_coord_sequencer
//  Description : Randomized bench for mandel_coord_sequencer with view model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mandel_coord_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value_in = '0;
    logic        input_x = 1'b0;
    logic        input_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        pixel_adv = 1'b0;
    logic [13:0] c_re, c_im;
    logic        cfg_pending, cfg_updated;

    always #5 clk = ~clk;

    mandel_coord_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .input_x     (input_x),
        .input_en    (input_en),
        .frame_start (frame_start),
        .line_start  (line_start),
        .pixel_adv   (pixel_adv),
        .c_re        (c_re),
        .c_im        (c_im),
        .cfg_pending (cfg_pending),
        .cfg_updated (cfg_updated)
    );

    int n_vec = 0;
    int n_err = 0;

    // View model: [axis 1=x,0=y][0=start,1=step]; c = start + count*step.
    logic [13:0] m_sh  [2][2];
    logic [13:0] m_act [2][2];
    bit          m_ptr [2];
    bit          m_dirty;
    bit          m_upd;
    int          npix, nline;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sh[1][0] = 14'h2000; m_sh[1][1] = 14'h0013;
        m_sh[0][0] = 14'h2C00; m_sh[0][1] = 14'h0015;
        m_act = m_sh;
        m_ptr[0] = 0; m_ptr[1] = 0;
        m_dirty = 0; m_upd = 0;
        npix = 0; nline = 0;
    endtask

    function automatic logic [13:0] exp_re();
        int p;
        p = npix * int'(m_act[1][1]);
        return m_act[1][0] + p[13:0];
    endfunction

    function automatic logic [13:0] exp_im();
        int p;
        p = nline * int'(m_act[0][1]);
        return m_act[0][0] + p[13:0];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".c_re"}, 32'(c_re), 32'(exp_re()));
        chk({tag, ".c_im"}, 32'(c_im), 32'(exp_im()));
        chk({tag, ".pending"}, 32'(cfg_pending), 32'(m_dirty));
        chk({tag, ".updated"}, 32'(cfg_updated), 32'(m_upd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit fs, input bit ls, input bit pa);
        frame_start = fs; line_start = ls; pixel_adv = pa;
        tick();
        frame_start = 0; line_start = 0; pixel_adv = 0;
        m_upd = 0;
        if (fs) begin
            if (m_dirty && !m_ptr[0] && !m_ptr[1]) begin
                m_act = m_sh;
                m_dirty = 0;
                m_upd = 1;
            end
            npix = 0; nline = 0;
        end else if (ls) begin
            npix = 0; nline++;
        end else if (pa) begin
            npix++;
        end
        check_all("step");
    endtask

    task automatic host_write(input bit ax, input logic [13:0] val);
        value_in = val; input_x = ax;
        tick();
        input_en = 1;
        repeat (4) tick();
        input_en = 0;
        repeat (3) tick();
        m_sh[ax][m_ptr[ax]] = val;
        m_ptr[ax] = ~m_ptr[ax];
        m_dirty = 1;
        m_upd = 0;
        check_all("write");
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        rst_n = 1;
        tick();
        check_all("reset");

        step(1, 0, 0);
        repeat (3) step(0, 0, 1);
        chk("three_pix_re", 32'(c_re), 32'h2039);
        step(0, 1, 0);
        chk("line_re", 32'(c_re), 32'h2000);
        chk("line_im", 32'(c_im), 32'h2C15);

        host_write(1, 14'h3000);
        host_write(1, 14'h0008);
        chk("pending_after_pair", 32'(cfg_pending), 32'h1);
        step(1, 0, 0);
        chk("commit_re", 32'(c_re), 32'h3000);
        step(0, 0, 1);
        chk("commit_pix_re", 32'(c_re), 32'h3008);

        host_write(1, 14'h2000);
        step(1, 0, 0);
        chk("half_pair_re", 32'(c_re), 32'h3000);
        host_write(1, 14'h3FFF);
        step(1, 0, 0);
        chk("neg_commit_re", 32'(c_re), 32'h2000);
        step(0, 0, 1);
        chk("wrap_re", 32'(c_re), 32'h1FFF);
        step(0, 1, 0);
        step(1, 1, 1);

        // Partial y write interrupted by reset must leave no trace.
        value_in = 14'h0123; input_x = 0;
        tick();
        input_en = 1;
        repeat (3) tick();
        rst_n = 0;
        #1;
        input_en = 0;
        tick();
        rst_n = 1;
        model_reset();
        tick();
        check_all("mid_reset");
        step(1, 0, 0);
        host_write(1, 14'h3800);
        host_write(1, 14'h0004);
        step(1, 0, 0);
        step(0, 1, 0);
        chk("post_reset_im", 32'(c_im), 32'h2C15);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8)       host_write(1'($urandom), 14'($urandom));
            else if (r < 15) step(1, 1'($urandom), 1'($urandom));
            else if (r < 30) step(0, 1, 1'($urandom));
            else if (r < 85) step(0, 0, 1);
            else             step(0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
